hamming_secded_enc_fifo: RTL and testbench
==========================================

Name: hamming_secded_enc_fifo

Overview:
- Parametrised successor to the fixed 11-to-16 Hamming encoder/storage stage.
- Accepts DATA_W-bit words on a valid/ready handshake and encodes each one to an extended Hamming (SECDED) codeword, or plain Hamming when SECDED=0.
- Buffers codewords in a DEPTH-entry FIFO and presents them on a valid/ready output toward the storage/channel path.

Parameters:
- DATA_W, 11: data bits per word; legal range 4..57.
- SECDED, 1: 1 adds an overall even-parity bit at codeword bit 0; 0 omits it.
- DEPTH, 4: FIFO entries; a power of two, 2..64.
- PAR_W, derived (localparam): smallest r with 2^r >= DATA_W+r+1; equals 4 for DATA_W=11.
- CODE_W, derived (localparam): DATA_W+PAR_W+SECDED; equals 16 for defaults.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  data_in is valid.
- in_ready  out  1  block can accept a word.
- data_in  in  DATA_W  raw data word.
- out_valid  out  1  code_out holds a valid codeword.
- out_ready  in  1  consumer accepts code_out.
- code_out  out  CODE_W  encoded codeword at the FIFO head.
- level  out  clog2(DEPTH)+1  number of codewords held.

Behaviour:
- Reset: while rst_n=0, asynchronously force in_ready=0, out_valid=0, code_out=0, level=0, and FIFO pointers=0. After release, in_ready=1 from the first edge.
- Codeword layout:
  - With SECDED=1, code_out[i] is Hamming position i for i=1..CODE_W-1; with SECDED=0, code_out[i] is position i+1.
  - Parity bit p(2^k) sits at position 2^k and is the even parity (XOR) of every position whose index has bit k set.
  - Data bits fill the non-power-of-two positions in ascending order, data_in[0] first.
  - With SECDED=1, code_out[0] = XOR of code_out[CODE_W-1:1], so whole-word parity is even.
- Push: on a rising edge with in_valid & in_ready, encode data_in combinationally and write it to the tail.
- Pop: on a rising edge with out_valid & out_ready, advance the head.
- Latency: a word accepted at edge N into an empty FIFO has out_valid=1 and code_out valid after edge N. There is no same-cycle fall-through.
- in_ready = (level != DEPTH), registered/derived from pointers only; it has no combinational path from out_ready.
- Full: in_ready=0. A push attempt is ignored even if a pop occurs in the same cycle; in_ready rises the cycle after the pop.
- Empty: out_valid=0 and code_out holds its last value. out_ready is ignored.
- Simultaneous push and pop when 0<level<DEPTH: level unchanged, both pointers advance.
- Pointers wrap modulo DEPTH. level tracks occupancy exactly: +1 on push only, -1 on pop only.
- code_out and out_valid are stable while out_valid=1 and out_ready=0.
- Reset mid-stream: all stored words are discarded; no partial output appears after reset.

Optional Feature:
- HAMMING_ERR_INJECT_EN defined:
  - Adds input err_mask [CODE_W-1:0].
  - At push, the stored codeword is the encoded word XOR err_mask, for decoder verification (single- and double-bit faults).
- Undefined: the port is absent and codewords are stored unmodified.

Decomposition:
- Package hamming_pkg:
  - function calc_par_w(data_w) returns PAR_W.
  - function is_pow2(pos).
  - constant MAX_DATA_W = 57.
- Sub-module hamming_enc_core (purely combinational, parameters DATA_W and SECDED): data_in to codeword.
- The FIFO is written inline in the top level.

Test Plan:
- Defaults; push data_in=11'h001 -> code_out=16'h000F one cycle later, level=1.
- Push 11'h7FF then 11'h000 -> code_out=16'hFFFF, then 16'h0000 after one pop, in order.
- out_ready=0, push 5 words with DEPTH=4 -> in_ready=0 after the 4th accept, 5th ignored, level=4. Pop one -> in_ready=1 next cycle.
- Random stream with random in_valid/out_ready for 10k words -> order preserved, every codeword has even total parity, and its syndrome is 0 in the reference model.
- Assert rst_n=0 asynchronously with level=3 -> out_valid=0, level=0 immediately, no stale words after release.
- DATA_W=26, SECDED=0 -> CODE_W=31; data_in=26'h1 -> code_out=31'h00000007.

Source files
------------

// File: rtl/hamming_pkg.sv
// Shared helpers for the Hamming encoder family: parity-width derivation and
// the mapping from data bit index to Hamming position.
package hamming_pkg;

    localparam int MAX_DATA_W = 57;

    // Smallest r with 2^r >= data_w + r + 1.
    function automatic int calc_par_w(input int data_w);
        int r;
        r = 1;
        while ((1 << r) < data_w + r + 1) r++;
        return r;
    endfunction

    function automatic bit is_pow2(input int pos);
        return (pos > 0) && ((pos & (pos - 1)) == 0);
    endfunction

    // Hamming position (1-based) occupied by data bit idx.
    function automatic int data_pos(input int idx);
        int cnt;
        int p;
        cnt = -1;
        p = 0;
        while (cnt < idx) begin
            p++;
            if (!is_pow2(p)) cnt++;
        end
        return p;
    endfunction

endpackage

// File: rtl/hamming_enc_core.sv
// Combinational Hamming encoder: scatters data into non-power-of-two positions
// and fills each power-of-two position with the even parity of its coverage set.
module hamming_enc_core
    import hamming_pkg::*;
#(
    parameter int DATA_W = 11,
    parameter int SECDED = 1,
    localparam int PAR_W = calc_par_w(DATA_W),
    localparam int CODE_W = DATA_W + PAR_W + SECDED
) (
    input  logic [DATA_W-1:0] data_in,
    output logic [CODE_W-1:0] code_out
);

    localparam int N = DATA_W + PAR_W;

    function automatic logic [N:1] cover_mask(input int k);
        logic [N:1] m;
        m = '0;
        for (int p = 1; p <= N; p++) m[p] = ((p >> k) & 1) == 1;
        return m;
    endfunction

    logic [N:1] dpos;
    logic [N:1] hpos;

    for (genvar i = 0; i < DATA_W; i++) begin : g_data
        assign dpos[data_pos(i)] = data_in[i];
    end

    // Parity slots are zero in dpos, so masking dpos never feeds a parity bit back on itself.
    for (genvar p = 1; p <= N; p++) begin : g_pos
        if (is_pow2(p)) begin : g_par
            assign dpos[p] = 1'b0;
            assign hpos[p] = ^(dpos & cover_mask($clog2(p)));
        end else begin : g_dat
            assign hpos[p] = dpos[p];
        end
    end

    if (SECDED != 0) begin : g_secded
        assign code_out = {hpos, ^hpos};
    end else begin : g_plain
        assign code_out = hpos;
    end

endmodule

// File: rtl/hamming_secded_enc_fifo.sv
// Hamming/SECDED encoder followed by a DEPTH-entry codeword FIFO with registered
// head. Define HAMMING_ERR_INJECT_EN to add err_mask, XORed into each stored word.
module hamming_secded_enc_fifo
    import hamming_pkg::*;
#(
    parameter int DATA_W = 11,
    parameter int SECDED = 1,
    parameter int DEPTH = 4,
    localparam int PAR_W = calc_par_w(DATA_W),
    localparam int CODE_W = DATA_W + PAR_W + SECDED,
    localparam int AW = $clog2(DEPTH),
    localparam int LW = AW + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] data_in,
`ifdef HAMMING_ERR_INJECT_EN
    input  logic [CODE_W-1:0] err_mask,
`endif
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CODE_W-1:0] code_out,
    output logic [LW-1:0]     level
);

    // Handshakes: a transfer happens on a rising edge where valid & ready are both 1;
    // valid never depends on ready, and ready is registered (no path from out_ready).

    logic [CODE_W-1:0] enc_word;
    logic [CODE_W-1:0] wr_word;
    logic [CODE_W-1:0] mem_q [DEPTH];

    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]     level_q, level_d;
    logic              in_ready_q, in_ready_d;
    logic              out_valid_q, out_valid_d;
    logic [CODE_W-1:0] code_q, code_d;
    logic              push, pop, head_is_new;

    hamming_enc_core #(
        .DATA_W (DATA_W),
        .SECDED (SECDED)
    ) u_enc (
        .data_in  (data_in),
        .code_out (enc_word)
    );

`ifdef HAMMING_ERR_INJECT_EN
    assign wr_word = enc_word ^ err_mask;
`else
    assign wr_word = enc_word;
`endif

    assign push = in_valid & in_ready_q;
    assign pop  = out_valid_q & out_ready;

    // The new word becomes the head directly when the FIFO is empty after this edge's pop.
    assign head_is_new = push && (level_q == (pop ? LW'(1) : LW'(0)));

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        unique case ({push, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
        in_ready_d  = (level_d != LW'(DEPTH));
        out_valid_d = (level_d != LW'(0));
        code_d      = code_q;
        if (out_valid_d) code_d = head_is_new ? wr_word : mem_q[rd_ptr_d];
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= wr_word;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            code_q      <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            code_q      <= code_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign code_out  = code_q;
    assign level     = level_q;

endmodule

// File: tb/tb_hamming_secded_enc_fifo.sv
// Bench for hamming_secded_enc_fifo: directed and random traffic against a
// syndrome-based encoder model and a queue model of the FIFO.
module tb_hamming_secded_enc_fifo;

    localparam int DEPTH = 4;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [10:0] data_in;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] code_out;
    logic [2:0]  level;

    logic        in_valid2;
    logic        in_ready2;
    logic [25:0] data_in2;
    logic        out_valid2;
    logic        out_ready2;
    logic [30:0] code_out2;
    logic [1:0]  level2;

    int          tests_run;
    int          tests_failed;
    logic [63:0] exp_q[$];
    logic [63:0] last_code;
    bit          model_live;
    int          n_push;

    hamming_secded_enc_fifo #(
        .DATA_W (11),
        .SECDED (1),
        .DEPTH  (DEPTH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .data_in   (data_in),
`ifdef HAMMING_ERR_INJECT_EN
        .err_mask  ('0),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .code_out  (code_out),
        .level     (level)
    );

    hamming_secded_enc_fifo #(
        .DATA_W (26),
        .SECDED (0),
        .DEPTH  (2)
    ) dut26 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid2),
        .in_ready  (in_ready2),
        .data_in   (data_in2),
`ifdef HAMMING_ERR_INJECT_EN
        .err_mask  ('0),
`endif
        .out_valid (out_valid2),
        .out_ready (out_ready2),
        .code_out  (code_out2),
        .level     (level2)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Parity bits are chosen so the XOR of the indices of all set positions is zero.
    function automatic logic [63:0] ref_encode(input logic [63:0] d, input int dw, input int sec);
        int          r;
        int          n;
        int          di;
        int          s;
        logic [63:0] pos;
        r = 1;
        while ((1 << r) < dw + r + 1) r++;
        n   = dw + r;
        pos = '0;
        di  = 0;
        s   = 0;
        for (int p = 1; p <= n; p++) begin
            if ((p & (p - 1)) != 0) begin
                pos[p] = d[di];
                if (d[di]) s = s ^ p;
                di++;
            end
        end
        for (int k = 0; k < r; k++) pos[1 << k] = s[k];
        if (sec != 0) begin
            pos[0] = ^pos;
            return pos;
        end
        return pos >> 1;
    endfunction

    function automatic int ref_syndrome(input logic [15:0] c);
        int s;
        s = 0;
        for (int i = 1; i < 16; i++) if (c[i]) s = s ^ i;
        return s;
    endfunction

    task automatic check_outputs();
        int sz;
        sz = exp_q.size();
        check_eq("level", 64'(level), 64'(sz));
        check_eq("in_ready", 64'(in_ready), 64'(model_live && sz != DEPTH));
        check_eq("out_valid", 64'(out_valid), 64'(sz != 0));
        check_eq("code_out", 64'(code_out), (sz != 0) ? exp_q[0] : last_code);
    endtask

    // driver: one cycle, inputs applied at the falling edge, transfer at the next rising edge
    task automatic do_cycle(input bit iv, input logic [10:0] d, input bit ordy);
        bit push;
        bit pop;
        @(negedge clk);
        check_outputs();
        in_valid  = iv;
        data_in   = d;
        out_ready = ordy;
        push = iv && model_live && (exp_q.size() != DEPTH);
        pop  = ordy && (exp_q.size() != 0);
        if (pop) begin
            check_eq("syndrome", 64'(ref_syndrome(code_out)), 64'(0));
            check_eq("even_parity", 64'(^code_out), 64'(0));
            last_code = exp_q.pop_front();
        end
        if (push) begin
            exp_q.push_back(ref_encode(64'(d), 11, 1));
            n_push++;
        end
    endtask

    initial begin
        int          cyc;
        int          target;
        logic [25:0] d26;
        logic [63:0] prev2;

        tests_run    = 0;
        tests_failed = 0;
        last_code    = '0;
        model_live   = 1'b0;
        n_push       = 0;
        rst_n        = 1'b0;
        in_valid     = 1'b0;
        data_in      = '0;
        out_ready    = 1'b0;
        in_valid2    = 1'b0;
        data_in2     = '0;
        out_ready2   = 1'b1;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_outputs();
        rst_n      = 1'b1;
        model_live = 1'b1;

        // single word, one-edge latency
        do_cycle(1'b1, 11'h001, 1'b0);
        @(posedge clk);
        #1;
        check_eq("enc_001", 64'(code_out), 64'h000F);
        check_eq("level_after_1", 64'(level), 64'd1);
        do_cycle(1'b0, 11'h000, 1'b1);

        // ordering of two words
        do_cycle(1'b1, 11'h7FF, 1'b0);
        do_cycle(1'b1, 11'h000, 1'b0);
        do_cycle(1'b0, 11'h000, 1'b0);
        check_eq("enc_7ff", 64'(code_out), 64'hFFFF);
        do_cycle(1'b0, 11'h000, 1'b1);
        do_cycle(1'b0, 11'h000, 1'b0);
        check_eq("enc_000", 64'(code_out), 64'h0000);
        check_eq("level_after_pop", 64'(level), 64'd1);
        do_cycle(1'b0, 11'h000, 1'b1);

        // fill past full, then pop one with a concurrent (ignored) push
        for (int i = 0; i < 5; i++) do_cycle(1'b1, 11'($urandom_range(0, 2047)), 1'b0);
        do_cycle(1'b0, 11'h000, 1'b0);
        check_eq("full_level", 64'(level), 64'd4);
        check_eq("full_in_ready", 64'(in_ready), 64'd0);
        do_cycle(1'b1, 11'h155, 1'b1);
        for (int i = 0; i < 4; i++) do_cycle(1'b0, 11'h000, 1'b1);

        // asynchronous reset with three words held
        for (int i = 0; i < 3; i++) do_cycle(1'b1, 11'($urandom_range(0, 2047)), 1'b0);
        do_cycle(1'b0, 11'h000, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("rst_level", 64'(level), 64'd0);
        check_eq("rst_out_valid", 64'(out_valid), 64'd0);
        check_eq("rst_in_ready", 64'(in_ready), 64'd0);
        check_eq("rst_code_out", 64'(code_out), 64'd0);
        exp_q.delete();
        last_code  = '0;
        model_live = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_outputs();
        rst_n      = 1'b1;
        model_live = 1'b1;
        for (int i = 0; i < 3; i++) do_cycle(1'b0, 11'h000, 1'b1);

        // random stream of 10k words
        target = n_push + 10000;
        cyc    = 0;
        while ((n_push < target || exp_q.size() != 0) && cyc < 60000) begin
            do_cycle((n_push < target) && ($urandom_range(0, 3) != 0),
                     11'($urandom_range(0, 2047)),
                     $urandom_range(0, 3) != 0);
            cyc++;
        end
        check_eq("stream_pushed", 64'(n_push), 64'(target));
        check_eq("stream_drained", 64'(exp_q.size()), 64'd0);
        do_cycle(1'b0, 11'h000, 1'b0);

        // 26-bit plain Hamming instance, back-to-back push/pop at level 1
        prev2 = '0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (i > 0) begin
                check_eq("w26_valid", 64'(out_valid2), 64'd1);
                check_eq("w26_code", 64'(code_out2), prev2);
            end
            if (i == 1) check_eq("w26_h1", 64'(code_out2), 64'h0000_0007);
            d26       = (i == 0) ? 26'h1 : 26'($urandom);
            in_valid2 = 1'b1;
            data_in2  = d26;
            prev2     = ref_encode(64'(d26), 26, 0);
        end
        @(negedge clk);
        in_valid2 = 1'b0;
        check_eq("w26_last", 64'(code_out2), prev2);
        @(negedge clk);
        check_eq("w26_empty", 64'(out_valid2), 64'd0);
        check_eq("w26_hold", 64'(code_out2), prev2);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
